// File: rtl/tx_frame_ctrler_pkg.sv
// Shared definitions for the Aurora LocalLink transmit path.
// The 70-bit beat layout is shared with the receive path.
package tx_frame_ctrler_pkg;

    localparam int unsigned BEAT_W    = 70;
    localparam int unsigned DATA_LSB  = 0;
    localparam int unsigned DATA_MSB  = 63;
    localparam int unsigned VALID_BIT = 64;
    localparam int unsigned EOP_BIT   = 65;
    localparam int unsigned SOP_BIT   = 66;
    localparam int unsigned MOD_LSB   = 67;
    localparam int unsigned MOD_MSB   = 69;

    // Remainder reported on every beat that is not the last of a frame
    localparam logic [2:0] REM_FULL = 3'b111;

    // Input framing checker states
    typedef enum logic {
        FR_IDLE,
        FR_IN_FRAME
    } frame_state_t;

    function automatic logic [BEAT_W-1:0] pack_beat(
        input logic [2:0]  mod,
        input logic        sop,
        input logic        eop,
        input logic        valid,
        input logic [63:0] data
    );
        return {mod, sop, eop, valid, data};
    endfunction

endpackage

// File: rtl/tx_frame_ctrler_fifo.sv
// sync_beat_fifo: single-clock beat buffer with occupancy count,
// full/empty flags and a synchronous flush. Head entry is visible on
// rd_data whenever empty is low. DEPTH must be a power of two.
module sync_beat_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed: entries are only read when counted
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous write and read keep count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_frame_ctrler.sv
// tx_frame_ctrler: buffers user beats and presents them on an Aurora
// LocalLink transmit interface with a one-beat output register.
// Optional input framing checker enabled by defining TX_FRAME_CHECK_EN.
module tx_frame_ctrler
    import tx_frame_ctrler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AFULL_LVL  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] txdata_i,
    input  logic        txdata_sop_i,
    input  logic        txdata_eop_i,
    input  logic        txdata_valid_i,
    input  logic [2:0]  txdata_mod_i,
    output logic        tx_ready_o,
    output logic [63:0] tx_d_o,
    output logic        tx_sof_n_o,
    output logic        tx_eof_n_o,
    output logic [2:0]  tx_rem_o,
    output logic        tx_src_rdy_n_o,
    input  logic        tx_dst_rdy_n_i,
    input  logic        channel_up_i,
    output logic        frame_err_o,
    output logic [15:0] tx_frame_cnt_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BEAT_W-1:0] fifo_head;
    logic [BEAT_W-1:0] wr_beat;
    logic              wr_en;
    logic              rd_en;
    logic              flush;
    logic              accept;
    logic              err_in;
    logic              run_q;

    logic              out_valid_q;
    logic [63:0]       d_q;
    logic              sof_n_q;
    logic              eof_n_q;
    logic [2:0]        rem_q;
    logic              xfer;
    logic              load;

    logic              frame_open_q;
    logic              frame_err_q;
    logic [15:0]       frame_cnt_q;

    assign flush = !channel_up_i;

    // free entries > AFULL_LVL, rewritten as count + AFULL_LVL < depth
    assign tx_ready_o = run_q && channel_up_i &&
                        ((32'(fifo_count) + AFULL_LVL) < FIFO_DEPTH);
    assign accept     = txdata_valid_i && tx_ready_o;

    // Holds tx_ready_o low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

`ifdef TX_FRAME_CHECK_EN
    frame_state_t state_q;
    frame_state_t state_d;

    // Framing checker state register, returns to IDLE on link loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FR_IDLE;
        end else if (flush) begin
            state_q <= FR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing checker: drop orphan beats, close frames cut by a new sop
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        err_in  = 1'b0;
        wr_beat = pack_beat(txdata_mod_i, txdata_sop_i, txdata_eop_i,
                            txdata_valid_i, txdata_i);
        if (accept) begin
            case (state_q)
                FR_IDLE: begin
                    if (txdata_sop_i) begin
                        wr_en = 1'b1;
                        if (!txdata_eop_i) begin
                            state_d = FR_IN_FRAME;
                        end
                    end else begin
                        err_in = 1'b1;
                    end
                end
                FR_IN_FRAME: begin
                    wr_en = 1'b1;
                    if (txdata_sop_i) begin
                        wr_beat = pack_beat(REM_FULL, 1'b0, 1'b1,
                                            txdata_valid_i, txdata_i);
                        err_in  = 1'b1;
                        state_d = FR_IDLE;
                    end else if (txdata_eop_i) begin
                        state_d = FR_IDLE;
                    end
                end
                default: state_d = FR_IDLE;
            endcase
        end
    end
`else
    // Beats pass into the buffer verbatim
    always_comb begin
        wr_en   = accept;
        err_in  = 1'b0;
        wr_beat = pack_beat(txdata_mod_i, txdata_sop_i, txdata_eop_i,
                            txdata_valid_i, txdata_i);
    end
`endif

    sync_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_en && !fifo_full),
        .wr_data (wr_beat),
        .rd_en   (rd_en),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign xfer  = out_valid_q && !tx_dst_rdy_n_i;
    assign load  = !out_valid_q || xfer;
    assign rd_en = load && !fifo_empty && !flush;

    // Output register: refills when empty or when its beat leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            sof_n_q     <= 1'b1;
            eof_n_q     <= 1'b1;
            rem_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            sof_n_q     <= 1'b1;
            eof_n_q     <= 1'b1;
            rem_q       <= '0;
        end else if (load) begin
            if (!fifo_empty) begin
                out_valid_q <= fifo_head[VALID_BIT];
                d_q         <= fifo_head[DATA_MSB:DATA_LSB];
                sof_n_q     <= ~fifo_head[SOP_BIT];
                eof_n_q     <= ~fifo_head[EOP_BIT];
                rem_q       <= fifo_head[EOP_BIT] ? fifo_head[MOD_MSB:MOD_LSB]
                                                  : REM_FULL;
            end else begin
                out_valid_q <= 1'b0;
                sof_n_q     <= 1'b1;
                eof_n_q     <= 1'b1;
                rem_q       <= '0;
            end
        end
    end

    // Frame counter, open-frame tracking and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            frame_open_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (xfer && !eof_n_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            frame_err_q <= err_in || (flush && frame_open_q);
            if (flush) begin
                frame_open_q <= 1'b0;
            end else if (xfer) begin
                if (!eof_n_q) begin
                    frame_open_q <= 1'b0;
                end else if (!sof_n_q) begin
                    frame_open_q <= 1'b1;
                end
            end
        end
    end

    assign tx_d_o         = d_q;
    assign tx_sof_n_o     = sof_n_q;
    assign tx_eof_n_o     = eof_n_q;
    assign tx_rem_o       = rem_q;
    assign tx_src_rdy_n_o = !out_valid_q;
    assign frame_err_o    = frame_err_q;
    assign tx_frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_ctrler.sv
// Self-checking bench for tx_frame_ctrler: table vectors, directed corner
// sequences and randomized traffic against a beat-queue reference model.
module tb_tx_frame_ctrler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] txdata_i = '0;
    logic        txdata_sop_i = 1'b0;
    logic        txdata_eop_i = 1'b0;
    logic        txdata_valid_i = 1'b0;
    logic [2:0]  txdata_mod_i = '0;
    logic        tx_ready_o;
    logic [63:0] tx_d_o;
    logic        tx_sof_n_o;
    logic        tx_eof_n_o;
    logic [2:0]  tx_rem_o;
    logic        tx_src_rdy_n_o;
    logic        tx_dst_rdy_n_i = 1'b0;
    logic        channel_up_i = 1'b1;
    logic        frame_err_o;
    logic [15:0] tx_frame_cnt_o;

    tx_frame_ctrler #(
        .FIFO_DEPTH (16),
        .AFULL_LVL  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .txdata_i       (txdata_i),
        .txdata_sop_i   (txdata_sop_i),
        .txdata_eop_i   (txdata_eop_i),
        .txdata_valid_i (txdata_valid_i),
        .txdata_mod_i   (txdata_mod_i),
        .tx_ready_o     (tx_ready_o),
        .tx_d_o         (tx_d_o),
        .tx_sof_n_o     (tx_sof_n_o),
        .tx_eof_n_o     (tx_eof_n_o),
        .tx_rem_o       (tx_rem_o),
        .tx_src_rdy_n_o (tx_src_rdy_n_o),
        .tx_dst_rdy_n_i (tx_dst_rdy_n_i),
        .channel_up_i   (channel_up_i),
        .frame_err_o    (frame_err_o),
        .tx_frame_cnt_o (tx_frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        sof_n;
        logic        eof_n;
        logic [2:0]  rem;
    } ll_beat_t;

    typedef struct {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        sof_n;
        logic        eof_n;
        logic [2:0]  rem;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model state: beats owed to LocalLink in order
    ll_beat_t    exp_q[$];
    ll_beat_t    got_q[$];
    int          got_cyc[$];
    int          cyc = 0;
    int          err_pulses = 0;
    logic        m_in_frame = 1'b0;
    logic        m_open = 1'b0;
    logic        m_err_now = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        prev_stall = 1'b0;
    ll_beat_t    prev_out;

    // What an accepted user beat should become on the LocalLink side
    task automatic model_accept(output logic err);
        ll_beat_t b;
        err     = 1'b0;
        b.d     = txdata_i;
        b.sof_n = !txdata_sop_i;
        b.eof_n = !txdata_eop_i;
        b.rem   = txdata_eop_i ? txdata_mod_i : 3'd7;
`ifdef TX_FRAME_CHECK_EN
        if (!m_in_frame) begin
            if (txdata_sop_i) begin
                exp_q.push_back(b);
                m_in_frame = !txdata_eop_i;
            end else begin
                err = 1'b1;
            end
        end else if (txdata_sop_i) begin
            b.sof_n = 1'b1;
            b.eof_n = 1'b0;
            b.rem   = 3'd7;
            exp_q.push_back(b);
            err = 1'b1;
            m_in_frame = 1'b0;
        end else begin
            exp_q.push_back(b);
            m_in_frame = !txdata_eop_i;
        end
`else
        exp_q.push_back(b);
`endif
    endtask

    // Monitor/scoreboard, sampling mid-cycle what the next edge will see
    always @(negedge clk) begin
        ll_beat_t cur;
        ll_beat_t e;
        logic     acc;
        logic     xf;
        logic     fl_err;
        logic     nerr;
        cyc++;
        cur = '{tx_d_o, tx_sof_n_o, tx_eof_n_o, tx_rem_o};
        if (!rst_n) begin
            exp_q.delete();
            m_in_frame = 1'b0;
            m_open     = 1'b0;
            m_err_now  = 1'b0;
            m_cnt      = '0;
            prev_stall = 1'b0;
        end else begin
            if (frame_err_o) err_pulses++;
            check("frame_err", 64'(frame_err_o), 64'(m_err_now));
            check("frame_cnt", 64'(tx_frame_cnt_o), 64'(m_cnt));
            if (prev_stall) begin
                check("stall_src_rdy", 64'(tx_src_rdy_n_o), 64'd0);
                check("stall_d", cur.d, prev_out.d);
                check("stall_sof", 64'(cur.sof_n), 64'(prev_out.sof_n));
                check("stall_eof", 64'(cur.eof_n), 64'(prev_out.eof_n));
                check("stall_rem", 64'(cur.rem), 64'(prev_out.rem));
            end
            acc    = txdata_valid_i && tx_ready_o;
            xf     = !tx_src_rdy_n_o && !tx_dst_rdy_n_i;
            fl_err = !channel_up_i && m_open;
            nerr   = 1'b0;
            if (xf) begin
                got_q.push_back(cur);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got beat %0h, required none", cur.d);
                end else begin
                    e = exp_q.pop_front();
                    check("out_d", cur.d, e.d);
                    check("out_sof_n", 64'(cur.sof_n), 64'(e.sof_n));
                    check("out_eof_n", 64'(cur.eof_n), 64'(e.eof_n));
                    check("out_rem", 64'(cur.rem), 64'(e.rem));
                    if (!e.eof_n) begin
                        m_open = 1'b0;
                        m_cnt  = m_cnt + 16'd1;
                    end else if (!e.sof_n) begin
                        m_open = 1'b1;
                    end
                end
            end
            if (!channel_up_i) begin
                exp_q.delete();
                m_open     = 1'b0;
                m_in_frame = 1'b0;
            end
            if (acc) model_accept(nerr);
            m_err_now  = nerr || fl_err;
            prev_stall = !tx_src_rdy_n_o && tx_dst_rdy_n_i && channel_up_i;
            prev_out   = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        txdata_valid_i = 1'b0;
        txdata_sop_i   = 1'b0;
        txdata_eop_i   = 1'b0;
        txdata_mod_i   = '0;
        txdata_i       = '0;
    endtask

    // Offer one beat until it is taken, bounded
    task automatic send_beat(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
        bit ok;
        ok = 1'b0;
        txdata_i = d; txdata_sop_i = s; txdata_eop_i = e; txdata_mod_i = m;
        txdata_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready_o) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        txdata_valid_i = 1'b0;
        check("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        tx_dst_rdy_n_i = 1'b0;
        idle_inputs();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && tx_src_rdy_n_o) break;
            tick();
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        tx_dst_rdy_n_i = 1'b0;
        channel_up_i   = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_src_rdy_n"}, 64'(tx_src_rdy_n_o), 64'd1);
        check({tag, "_sof_n"}, 64'(tx_sof_n_o), 64'd1);
        check({tag, "_eof_n"}, 64'(tx_eof_n_o), 64'd1);
        check({tag, "_d"}, tx_d_o, 64'd0);
        check({tag, "_rem"}, 64'(tx_rem_o), 64'd0);
        check({tag, "_ready"}, 64'(tx_ready_o), 64'd0);
        check({tag, "_err"}, 64'(frame_err_o), 64'd0);
        check({tag, "_cnt"}, 64'(tx_frame_cnt_o), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   accepted;
        int   e0;

        vecs[0] = '{64'h1111_0000_0000_0001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7};
        vecs[1] = '{64'h1111_0000_0000_0002, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd7};
        vecs[2] = '{64'h1111_0000_0000_0003, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0};
        vecs[4] = '{64'h0000_0000_0000_0000, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 3'd7};
        vecs[5] = '{64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 3'd7};
        vecs[6] = '{64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd7};
        vecs[7] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 3'd7};

        // Reset values while rst_n is low
        tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single-beat frame latency
        check("ready_after_reset", 64'(tx_ready_o), 64'd1);
        got_q.delete();
        send_beat(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 3'd3);
        tick();
        check("lat_src_rdy_n", 64'(tx_src_rdy_n_o), 64'd0);
        check("lat_sof_n", 64'(tx_sof_n_o), 64'd0);
        check("lat_eof_n", 64'(tx_eof_n_o), 64'd0);
        check("lat_rem", 64'(tx_rem_o), 64'd3);
        check("lat_d", tx_d_o, 64'h0123_4567_89AB_CDEF);
        tick();
        check("lat_cnt", 64'(tx_frame_cnt_o), 64'd1);
        drain();

        // Table vectors streamed back to back
        got_q.delete();
        got_cyc.delete();
        for (int i = 0; i < 8; i++) send_beat(vecs[i].d, vecs[i].sop, vecs[i].eop, vecs[i].mod);
        drain();
        check("tbl_count", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("tbl%0d_d", i), got_q[i].d, vecs[i].d);
                check($sformatf("tbl%0d_sof_n", i), 64'(got_q[i].sof_n), 64'(vecs[i].sof_n));
                check($sformatf("tbl%0d_eof_n", i), 64'(got_q[i].eof_n), 64'(vecs[i].eof_n));
                check($sformatf("tbl%0d_rem", i), 64'(got_q[i].rem), 64'(vecs[i].rem));
            end
            check("tbl_no_bubbles", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
        end

        // Four-beat frame stalled for 5 cycles mid-frame
        got_q.delete();
        send_beat(64'hC0, 1'b1, 1'b0, 3'd0);
        send_beat(64'hC1, 1'b0, 1'b0, 3'd0);
        send_beat(64'hC2, 1'b0, 1'b0, 3'd0);
        tx_dst_rdy_n_i = 1'b1;
        send_beat(64'hC3, 1'b0, 1'b1, 3'd4);
        repeat (4) tick();
        check("stall5_src_rdy_n", 64'(tx_src_rdy_n_o), 64'd0);
        check("stall5_d", tx_d_o, 64'hC1);
        check("stall5_sof_n", 64'(tx_sof_n_o), 64'd1);
        check("stall5_rem", 64'(tx_rem_o), 64'd7);
        drain();
        check("stall_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("stall_beat%0d_d", i), got_q[i].d, 64'hC0 + 64'(i));
                check($sformatf("stall_beat%0d_rem", i), 64'(got_q[i].rem), (i == 3) ? 64'd4 : 64'd7);
            end
        end

        // Fill without drain: 14 FIFO entries plus the output register
        got_q.delete();
        tx_dst_rdy_n_i = 1'b1;
        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            if (!tx_ready_o) break;
            txdata_i = 64'h100 + 64'(accepted);
            txdata_sop_i = 1'b1; txdata_eop_i = 1'b1; txdata_mod_i = 3'd7;
            txdata_valid_i = 1'b1;
            tick();
            accepted++;
        end
        check("fill_accepted", 64'(accepted), 64'd15);
        txdata_i = 64'hBAD;
        repeat (3) tick();
        check("fill_ready_low", 64'(tx_ready_o), 64'd0);
        drain();
        check("fill_drained", 64'(got_q.size()), 64'd15);
        if (got_q.size() == 15) begin
            for (int i = 0; i < 15; i++) check($sformatf("fill%0d_d", i), got_q[i].d, 64'h100 + 64'(i));
        end

`ifdef TX_FRAME_CHECK_EN
        // sop, data, sop again: third beat closes the frame with an error
        got_q.delete();
        e0 = err_pulses;
        send_beat(64'hF0, 1'b1, 1'b0, 3'd0);
        send_beat(64'hF1, 1'b0, 1'b0, 3'd0);
        send_beat(64'hF2, 1'b1, 1'b0, 3'd2);
        drain();
        check("chk_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check("chk_sof_n", 64'(got_q[2].sof_n), 64'd1);
            check("chk_eof_n", 64'(got_q[2].eof_n), 64'd0);
            check("chk_rem", 64'(got_q[2].rem), 64'd7);
        end
        check("chk_err_pulses", 64'(err_pulses - e0), 64'd1);
`endif

        // Link drop mid-frame: flush and one error pulse
        got_q.delete();
        send_beat(64'hE0, 1'b1, 1'b0, 3'd0);
        send_beat(64'hE1, 1'b0, 1'b0, 3'd0);
        repeat (3) tick();
        tx_dst_rdy_n_i = 1'b1;
        send_beat(64'hE2, 1'b0, 1'b0, 3'd0);
        send_beat(64'hE3, 1'b0, 1'b0, 3'd0);
        channel_up_i = 1'b0;
        tick();
        check("down_src_rdy_n", 64'(tx_src_rdy_n_o), 64'd1);
        check("down_err", 64'(frame_err_o), 64'd1);
        check("down_ready", 64'(tx_ready_o), 64'd0);
        tick();
        check("down_err_once", 64'(frame_err_o), 64'd0);
        channel_up_i = 1'b1;
        #1;
        check("up_ready_empty", 64'(tx_ready_o), 64'd1);
        tx_dst_rdy_n_i = 1'b0;
        repeat (5) tick();
        check("up_nothing_sent", 64'(tx_src_rdy_n_o), 64'd1);
        check("down_sent_count", 64'(got_q.size()), 64'd2);

        // Reset mid-frame discards buffered beats
        got_q.delete();
        tx_dst_rdy_n_i = 1'b1;
        send_beat(64'hD0, 1'b1, 1'b0, 3'd0);
        send_beat(64'hD1, 1'b0, 1'b0, 3'd0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        tx_dst_rdy_n_i = 1'b0;
        repeat (5) tick();
        check("midrst_nothing_sent", 64'(got_q.size()), 64'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            txdata_valid_i = ($urandom_range(0, 9) < 7);
            txdata_sop_i   = $urandom_range(0, 1);
            txdata_eop_i   = $urandom_range(0, 1);
            txdata_mod_i   = 3'($urandom);
            txdata_i       = {$urandom, $urandom};
            tx_dst_rdy_n_i = ($urandom_range(0, 9) < 3);
            channel_up_i   = ($urandom_range(0, 99) >= 2);
            tick();
        end
        channel_up_i = 1'b1;
        drain();

        // 65537 single-beat frames: counter wraps to 1
        do_reset();
        txdata_sop_i = 1'b1; txdata_eop_i = 1'b1; txdata_mod_i = 3'd0;
        accepted = 0;
        for (int i = 0; i < 70000 && accepted < 65537; i++) begin
            txdata_i = 64'(i);
            txdata_valid_i = 1'b1;
            if (tx_ready_o) accepted++;
            tick();
        end
        txdata_valid_i = 1'b0;
        check("wrap_accepted", 64'(accepted), 64'd65537);
        drain();
        tick();
        check("wrap_cnt", 64'(tx_frame_cnt_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_ctrler.md
TX_FRAME_CTRLER -- requirements
Module: tx_frame_ctrler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the sole clock, and rst_n is the asynchronous active-low reset.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two, SHALL set the internal beat buffer depth.
REQ-003 Parameter AFULL_LVL, default 2, SHALL set how many free entries remain when tx_ready_o deasserts.
REQ-004 Ports, one per line:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- txdata_i  in  64  user beat data
- txdata_sop_i  in  1  first beat of frame
- txdata_eop_i  in  1  last beat of frame
- txdata_valid_i  in  1  beat present
- txdata_mod_i  in  3  valid bytes minus 1 on eop beat
- tx_ready_o  out  1  block can take a beat
- tx_d_o  out  64  Aurora LocalLink data
- tx_sof_n_o  out  1  active-low start of frame
- tx_eof_n_o  out  1  active-low end of frame
- tx_rem_o  out  3  remainder
- tx_src_rdy_n_o  out  1  active-low source ready
- tx_dst_rdy_n_i  in  1  active-low destination ready
- channel_up_i  in  1  Aurora link up
- frame_err_o  out  1  one-cycle framing error pulse
- tx_frame_cnt_o  out  16  count of frames sent

Function
REQ-005 A user beat SHALL be accepted on the edge where txdata_valid_i=1 and tx_ready_o=1; a beat offered while tx_ready_o=0 SHALL be ignored.
REQ-006 tx_ready_o SHALL be 1 only while free entries > AFULL_LVL and channel_up_i=1.
REQ-007 Each accepted beat SHALL be stored as 70 bits, packed as {mod[2:0], sop, eop, valid, data[63:0]}, in a synchronous FIFO of FIFO_DEPTH entries.
REQ-008 An output register SHALL load the FIFO head whenever it is empty, or whenever its beat is transferred in the same cycle.
REQ-009 A LocalLink transfer SHALL occur on the edge where tx_src_rdy_n_o=0 and tx_dst_rdy_n_i=0.
REQ-010 While tx_src_rdy_n_o=0 and tx_dst_rdy_n_i=1, all tx_* outputs SHALL hold stable.
REQ-011 Latency SHALL be 2 edges: a beat accepted at edge N into an empty block is presented, with tx_src_rdy_n_o=0, after edge N+1.
REQ-012 With continuous tx_dst_rdy_n_i=0, throughput SHALL be one beat per cycle with no bubbles.
REQ-013 tx_sof_n_o SHALL be ~sop and tx_eof_n_o SHALL be ~eop; tx_rem_o SHALL be the stored mod on eop beats and 3'b111 otherwise.
REQ-014 tx_frame_cnt_o SHALL increment by 1 on each transferred eop beat and wrap from 16'hFFFF to 0.
REQ-015 Simultaneous FIFO write and read SHALL leave the occupancy unchanged; a write when the FIFO is full SHALL never occur.
REQ-016 When channel_up_i=0, the FIFO and output register SHALL flush, tx_src_rdy_n_o SHALL be 1, and frame_err_o SHALL pulse if a frame was open (sop transferred without its eop).

Reset
REQ-017 While rst_n=0, the outputs SHALL take these values: tx_src_rdy_n_o=1, tx_sof_n_o=1, tx_eof_n_o=1, tx_d_o=0, tx_rem_o=0, tx_ready_o=0, frame_err_o=0, tx_frame_cnt_o=0.
REQ-018 While rst_n=0, the FIFO SHALL be empty and the framing FSM SHALL be in IDLE.
REQ-019 Reset asserted mid-frame SHALL discard all buffered beats without emitting eof.

Configuration
REQ-020 With TX_FRAME_CHECK_EN defined, an input framing FSM SHALL run with states IDLE and IN_FRAME.
- IDLE: a beat with sop is written; eop also set -> stay IDLE, otherwise -> IN_FRAME. A beat without sop is discarded and frame_err_o pulses.
- IN_FRAME: a beat with eop is written -> IDLE. A beat with sop is written with sop cleared, eop forced to 1 and mod=7, frame_err_o pulses -> IDLE.
REQ-021 Without TX_FRAME_CHECK_EN, beats SHALL pass verbatim, no FSM SHALL exist, and frame_err_o SHALL be driven only by REQ-016.

Structure
REQ-022 A shared package SHALL hold the 70-bit beat field offsets (DATA 63:0, VALID 64, EOP 65, SOP 66, MOD 69:67) and the REM_FULL=3'b111 constant; these offsets are shared with the receive path.
REQ-023 The synchronous FIFO SHALL be one sub-module, sync_beat_fifo, providing count, full and empty; the framing FSM and output register SHALL stay in the top level.

Verification
REQ-024 A single beat with sop=eop=1, mod=3, data=64'h0123456789ABCDEF and dst_rdy_n=0 -> after 2 edges: sof_n=0, eof_n=0, rem=3, data matches, frame_cnt=1.
REQ-025 A 4-beat frame with dst_rdy_n held 1 for 5 cycles mid-frame -> outputs stable while stalled, all 4 beats in order, rem=7 on beats 1-3.
REQ-026 Fill without drain, FIFO_DEPTH=16 -> tx_ready_o drops at 14 entries; no beat lost after drain.
REQ-027 With TX_FRAME_CHECK_EN: sop, data, then sop again -> third beat emitted with sof_n=1, eof_n=0, rem=7, one frame_err_o pulse.
REQ-028 channel_up_i falls mid-frame -> src_rdy_n=1 next cycle, frame_err_o pulses once, FIFO empty.
REQ-029 65537 single-beat frames -> tx_frame_cnt_o wraps to 1.
